// File: rtl/wb_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wb_wr_scheduler
// Brief    : Two-requester round-robin Wishbone write master. Each granted
//            request becomes one single-beat write (CYC/STB/WE), ended by
//            ACK_I (done_o) or by a bus timeout (err_o). A fixed idle gap
//            follows every transaction.
// Revision : 1.0 - initial release
// ============================================================================
module wb_wr_scheduler #(
    parameter int TIMEOUT = 64,   // max STB_O cycles without ACK_I (2..1023)
    parameter int GAP_CYC = 4     // idle cycles after each transaction (1..255)
) (
    input  logic        CLK_I,
    input  logic        RST_I,        // asynchronous, active-low

    input  logic [1:0]  req_i,
    input  logic [31:0] adr0_i,
    input  logic [31:0] adr1_i,
    input  logic [31:0] dat0_i,
    input  logic [31:0] dat1_i,
    output logic [1:0]  done_o,
    output logic [1:0]  err_o,
    input  logic        ser_busy_i,

    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    input  logic        ACK_I
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Terminal counts: the BUS counter starts at 0 on entry, so the last
    // permitted STB cycle is TIMEOUT-1; likewise for the gap counter.
    localparam logic [9:0] C_TO_LAST  = 10'(TIMEOUT - 1);
    localparam logic [7:0] C_GAP_LAST = 8'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic        cyc_q,   cyc_d;
    logic [31:0] adr_q,   adr_d;
    logic [31:0] dat_q,   dat_d;
    logic        last_q,  last_d;     // requester granted most recently
    logic [9:0]  tcnt_q,  tcnt_d;     // BUS cycles elapsed without ACK
    logic [7:0]  gcnt_q,  gcnt_d;     // GAP cycles elapsed
    logic [1:0]  done_q,  done_d;
    logic [1:0]  err_q,   err_d;

    logic        gnt_sel;             // requester chosen if a grant happens now
    logic [1:0]  owner_bit;           // one-hot of the current bus owner

    // Round-robin choice: on a tie the requester not granted last wins.
    // last_q resets to 1 so requester 0 wins the first tie.
    always_comb begin
        gnt_sel = 1'b0;
        case (req_i)
            2'b01:   gnt_sel = 1'b0;
            2'b10:   gnt_sel = 1'b1;
            2'b11:   gnt_sel = ~last_q;
            default: gnt_sel = 1'b0;
        endcase
    end

    assign owner_bit = last_q ? 2'b10 : 2'b01;

    // Next-state and next-output computation for the IDLE/BUS/GAP sequencer.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        done_d  = 2'b00;
        err_d   = 2'b00;

        case (state_q)
            ST_IDLE: begin
                // Requests are only looked at here; the serializer being
                // busy defers the grant without losing the request.
                if (!ser_busy_i && (req_i != 2'b00)) begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    last_d  = gnt_sel;
                    adr_d   = gnt_sel ? adr1_i : adr0_i;
                    dat_d   = gnt_sel ? dat1_i : dat0_i;
                    tcnt_d  = 10'd0;
                end
            end

            ST_BUS: begin
                // ACK is tested before the timeout so an ACK on the last
                // allowed cycle still completes successfully.
                if (ACK_I) begin
                    state_d = ST_GAP;
                    cyc_d   = 1'b0;
                    adr_d   = 32'd0;
                    dat_d   = 32'd0;
                    done_d  = owner_bit;
                    gcnt_d  = 8'd0;
                end else if (tcnt_q == C_TO_LAST) begin
                    state_d = ST_GAP;
                    cyc_d   = 1'b0;
                    adr_d   = 32'd0;
                    dat_d   = 32'd0;
                    err_d   = owner_bit;
                    gcnt_d  = 8'd0;
                end else begin
                    tcnt_d  = tcnt_q + 10'd1;
                end
            end

            ST_GAP: begin
                if (gcnt_q == C_GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d  = gcnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                adr_d   = 32'd0;
                dat_d   = 32'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            last_q  <= 1'b1;
            tcnt_q  <= 10'd0;
            gcnt_q  <= 8'd0;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Single-beat writes: CYC, STB and WE always move together.
    assign CYC_O  = cyc_q;
    assign STB_O  = cyc_q;
    assign WE_O   = cyc_q;
    assign ADR_O  = adr_q;
    assign DAT_O  = dat_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_wr_scheduler
// Brief    : Directed self-checking bench for wb_wr_scheduler
//            (TIMEOUT=8, GAP_CYC=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_wr_scheduler;

    localparam int TO  = 8;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] adr0, adr1, dat0, dat1;
    logic        busy;
    logic        ack;
    logic [1:0]  done, err;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;

    int n_checks = 0;
    int n_errors = 0;
    int n;
    int hi;

    always #5 clk = ~clk;

    wb_wr_scheduler #(
        .TIMEOUT (TO),
        .GAP_CYC (GAP)
    ) u_dut (
        .CLK_I      (clk),
        .RST_I      (rst_n),
        .req_i      (req),
        .adr0_i     (adr0),
        .adr1_i     (adr1),
        .dat0_i     (dat0),
        .dat1_i     (dat1),
        .done_o     (done),
        .err_o      (err),
        .ser_busy_i (busy),
        .CYC_O      (cyc),
        .STB_O      (stb),
        .WE_O       (we),
        .ADR_O      (adr),
        .DAT_O      (dat),
        .ACK_I      (ack)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until CYC rises (bounded); returns the number of edges taken.
    task automatic wait_cyc(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (cnt == 1) check_val("pulse_clear", {done, err}, 4'b0000);
        end while (!cyc && cnt < 200);
    endtask

    // Called in the first CYC-high cycle. ack_at = STB cycle (1-based) in
    // which ACK is driven; 0 means never (expect timeout).
    task automatic bus_txn(input string tag, input int k, input logic [31:0] ea,
                           input logic [31:0] ed, input int ack_at);
        int         cnt;
        int         exp_n;
        logic [1:0] kbit;
        bit         going;
        kbit  = (k == 1) ? 2'b10 : 2'b01;
        exp_n = (ack_at == 0) ? TO : ack_at;
        check_val({tag, "_cyc_stb_we"}, {cyc, stb, we}, 3'b111);
        check_val({tag, "_adr"}, adr, ea);
        check_val({tag, "_dat"}, dat, ed);
        cnt   = 1;
        going = 1'b1;
        while (going) begin
            if (cnt == ack_at) ack = 1'b1;
            tick();
            ack = 1'b0;
            if (cyc && cnt < 200) begin
                check_val({tag, "_no_pulse_in_bus"}, {done, err}, 4'b0000);
                check_val({tag, "_adr_hold"}, adr, ea);
                cnt++;
            end else begin
                going = 1'b0;
            end
        end
        check_val({tag, "_stb_cycles"}, cnt, exp_n);
        check_val({tag, "_bus_low"}, {cyc, stb, we}, 3'b000);
        check_val({tag, "_done"}, done, (ack_at != 0) ? kbit : 2'b00);
        check_val({tag, "_err"}, err, (ack_at == 0) ? kbit : 2'b00);
        check_val({tag, "_adr_dat_zero"}, {adr, dat}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        busy  = 1'b0;
        ack   = 1'b0;
        adr0  = 32'h0000_0000;
        dat0  = 32'h0003_0201;
        adr1  = 32'h1000_0004;
        dat1  = 32'hB1B1_0001;

        // Reset state
        repeat (3) tick();
        check_val("rst_bus", {cyc, stb, we}, 3'b000);
        check_val("rst_adr_dat", {adr, dat}, 64'd0);
        check_val("rst_done_err", {done, err}, 4'b0000);
        rst_n = 1'b1;

        // A: single write from requester 0, ACK in 4th STB cycle
        req = 2'b01;
        wait_cyc(n);
        check_val("A_grant_lat", n, 1);
        req = 2'b00;
        bus_txn("A", 0, 32'h0000_0000, 32'h0003_0201, 4);

        // B: both requesting, immediate ACK; last grant was 0 so 1,0,1,0
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(n);
            check_val($sformatf("B%0d_gap_len", i), n, GAP + 1);
            if (i % 2 == 0)
                bus_txn($sformatf("B%0d", i), 1, 32'h1000_0004, 32'hB1B1_0001, 1);
            else
                bus_txn($sformatf("B%0d", i), 0, 32'h0000_0000, 32'h0003_0201, 1);
        end
        req = 2'b00;
        hi = 0;
        for (int i = 0; i < GAP + 3; i++) begin
            tick();
            if (cyc) hi++;
        end
        check_val("B_no_extra_grant", hi, 0);

        // C: no ACK -> timeout after exactly TO cycles
        adr0 = 32'h0000_0C00;
        dat0 = 32'h0C0C_0C0C;
        req  = 2'b01;
        wait_cyc(n);
        check_val("C_grant_lat", n, 1);
        req = 2'b00;
        bus_txn("C", 0, 32'h0000_0C00, 32'h0C0C_0C0C, 0);
        // ACK in GAP is ignored
        ack = 1'b1;
        tick();
        check_val("C_gap_ack_ignored", {cyc, done, err}, 5'b0);
        ack = 1'b0;
        repeat (GAP + 1) tick();
        // ACK in IDLE is ignored
        ack = 1'b1;
        tick();
        check_val("C_idle_ack_ignored", {cyc, done, err}, 5'b0);
        ack = 1'b0;

        // D: ACK on the 8th (last) STB cycle counts as success
        adr0 = 32'hA0A0_0008;
        dat0 = 32'hDEAD_BEEF;
        req  = 2'b01;
        wait_cyc(n);
        check_val("D_grant_lat", n, 1);
        req = 2'b00;
        bus_txn("D", 0, 32'hA0A0_0008, 32'hDEAD_BEEF, 8);
        repeat (GAP + 1) tick();

        // E: serializer busy for 20 cycles holds the block in IDLE
        busy = 1'b1;
        req  = 2'b10;
        hi   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cyc) hi++;
        end
        check_val("E_busy_hold", hi, 0);
        busy = 1'b0;
        wait_cyc(n);
        check_val("E_grant_lat", n, 1);
        req  = 2'b00;
        busy = 1'b1;     // ignored in BUS and GAP
        bus_txn("E", 1, 32'h1000_0004, 32'hB1B1_0001, 2);
        busy = 1'b0;
        repeat (GAP + 1) tick();

        // F: reset in the 2nd BUS cycle, then priority back to requester 0
        req = 2'b10;
        wait_cyc(n);
        check_val("F_grant_lat", n, 1);
        tick();
        check_val("F_bus_cycle2", cyc, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("F_async_bus", {cyc, stb, we}, 3'b000);
        check_val("F_async_adr_dat", {adr, dat}, 64'd0);
        check_val("F_async_done_err", {done, err}, 4'b0000);
        req = 2'b11;
        ack = 1'b1;
        repeat (2) tick();
        check_val("F_in_reset", {cyc, done, err}, 5'b0);
        ack   = 1'b0;
        rst_n = 1'b1;
        wait_cyc(n);
        check_val("F_regrant_lat", n, 1);
        req = 2'b00;
        bus_txn("F", 0, 32'hA0A0_0008, 32'hDEAD_BEEF, 1);
        repeat (GAP + 1) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
